// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source holding FIFOs, round-robin grant, one registered broadcast per cycle.
// Latency 2 edges (1 edge with CDB_BYPASS_EN defined); src_ready = FIFO not full; flush squashes all in flight.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_IDX_W  = 5
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       flush,
  input  logic [NUM_SRC-1:0]                         src_valid,
  output logic [NUM_SRC-1:0]                         src_ready,
  input  logic [NUM_SRC*(`PHYS_REG_IDX_SZ+1)-1:0]    src_dest_idx,
  input  logic [NUM_SRC*`XLEN-1:0]                   src_data,
  input  logic [NUM_SRC*ROB_IDX_W-1:0]               src_rob_idx,
  output logic                                       cdb_valid,
  output logic [`PHYS_REG_IDX_SZ:0]                  cdb_dest_idx,
  output logic [`XLEN-1:0]                           cdb_data,
  output logic [ROB_IDX_W-1:0]                       cdb_rob_idx,
  output logic [$clog2(NUM_SRC)-1:0]                 cdb_src
);

  localparam int DW = `PHYS_REG_IDX_SZ + 1;
  localparam int XW = `XLEN;
  localparam int PW = DW + XW + ROB_IDX_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(NUM_SRC);

  logic [PW-1:0]      mem      [NUM_SRC][FIFO_DEPTH];
  logic [PW-1:0]      src_pay  [NUM_SRC];
  logic [PW-1:0]      head_pay [NUM_SRC];
  logic [AW-1:0]      wptr     [NUM_SRC];
  logic [AW-1:0]      rptr     [NUM_SRC];
  logic [AW:0]        count    [NUM_SRC];

  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] byp_cand;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] bypass_win;

  logic [SW-1:0]      last_grant;
  logic [SW-1:0]      gnt_idx;
  logic               gnt_vld;
  logic               do_grant;
  logic [PW-1:0]      win_pay;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_pay[i]   = {src_dest_idx[i*DW +: DW], src_data[i*XW +: XW],
                      src_rob_idx[i*ROB_IDX_W +: ROB_IDX_W]};
      head_pay[i]  = mem[i][rptr[i]];
      empty[i]     = (count[i] == '0);
      src_ready[i] = (count[i] != (AW+1)'(FIFO_DEPTH));
    end
  end

`ifdef CDB_BYPASS_EN
  // An empty FIFO with a live request competes directly with its input payload.
  assign byp_cand = empty & src_valid;
`else
  assign byp_cand = '0;
`endif

  assign eligible = ~empty | byp_cand;

  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = last_grant;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(last_grant) + k) % NUM_SRC;
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
  end

  assign do_grant = gnt_vld && !flush;
  assign win_pay  = byp_cand[gnt_idx] ? src_pay[gnt_idx] : head_pay[gnt_idx];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      bypass_win[i] = do_grant && (gnt_idx == SW'(i)) && byp_cand[i];
      pop[i]        = do_grant && (gnt_idx == SW'(i)) && !empty[i];
      push[i]       = src_valid[i] && src_ready[i] && !flush && !bypass_win[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
        if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
        else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wptr[i]] <= src_pay[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_valid    <= 1'b0;
      cdb_dest_idx <= '0;
      cdb_data     <= '0;
      cdb_rob_idx  <= '0;
      cdb_src      <= '0;
      last_grant   <= SW'(NUM_SRC - 1);
    end else if (flush) begin
      cdb_valid    <= 1'b0;
    end else if (gnt_vld) begin
      cdb_valid    <= 1'b1;
      cdb_dest_idx <= win_pay[PW-1 -: DW];
      cdb_data     <= win_pay[ROB_IDX_W +: XW];
      cdb_rob_idx  <= win_pay[ROB_IDX_W-1:0];
      cdb_src      <= gnt_idx;
      last_grant   <= gnt_idx;
    end else begin
      cdb_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts, a negedge monitor pops and compares.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PHYS_REG_IDX_SZ
`define PHYS_REG_IDX_SZ 6
`endif

module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = `PHYS_REG_IDX_SZ + 1;
  localparam int XW = `XLEN;
  localparam int RW = 5;
  localparam int PW = DW + XW + RW;

  logic              clock;
  logic              reset;
  logic              flush;
  logic [N-1:0]      src_valid;
  logic [N-1:0]      src_ready;
  logic [N*DW-1:0]   src_dest_idx;
  logic [N*XW-1:0]   src_data;
  logic [N*RW-1:0]   src_rob_idx;
  logic              cdb_valid;
  logic [DW-1:0]     cdb_dest_idx;
  logic [XW-1:0]     cdb_data;
  logic [RW-1:0]     cdb_rob_idx;
  logic [1:0]        cdb_src;

  cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(2), .ROB_IDX_W(RW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_dest_idx(src_dest_idx), .src_data(src_data), .src_rob_idx(src_rob_idx),
    .cdb_valid(cdb_valid), .cdb_dest_idx(cdb_dest_idx), .cdb_data(cdb_data),
    .cdb_rob_idx(cdb_rob_idx), .cdb_src(cdb_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [PW-1:0] exp_q [N][$];
  int            exp_order [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    exp_order.delete();
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < N; i++) n += exp_q[i].size();
    return n;
  endfunction

  // Monitor: every broadcast must match the head of its source's expected queue.
  initial begin
    logic [PW-1:0] e;
    int s, o;
    forever begin
      @(negedge clock);
      if (reset && cdb_valid) begin
        s = int'(cdb_src);
        if (exp_q[s].size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_bcast: src %0d data %0h, required no broadcast", s, cdb_data);
        end else begin
          e = exp_q[s].pop_front();
          chk("bcast_payload", 64'({cdb_dest_idx, cdb_data, cdb_rob_idx}), 64'(e));
        end
        if (exp_order.size() > 0) begin
          o = exp_order.pop_front();
          chk("bcast_order", 64'(cdb_src), 64'(o));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic set_src(input int i, input logic [DW-1:0] d, input logic [XW-1:0] x,
                         input logic [RW-1:0] r, input bit expect_it);
    src_dest_idx[i*DW +: DW] = d;
    src_data[i*XW +: XW]     = x;
    src_rob_idx[i*RW +: RW]  = r;
    src_valid[i]             = 1'b1;
    if (expect_it) exp_q[i].push_back({d, x, r});
  endtask

  // All drive tasks start and end at posedge+1.
  task automatic drive_one(input int i, input logic [DW-1:0] d, input logic [XW-1:0] x,
                           input logic [RW-1:0] r);
    set_src(i, d, x, r, 1'b1);
    @(posedge clock); #1;
    src_valid = '0;
  endtask

  task automatic drive_cycle(input logic [N-1:0] mask, input logic [7:0] tag);
    for (int i = 0; i < N; i++)
      if (mask[i]) set_src(i, DW'(tag + 8'(i)), {24'hA0_0000, tag} + XW'(i << 16), RW'(tag + 8'(i)), 1'b1);
    @(posedge clock); #1;
    src_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; flush = 1'b0; src_valid = '0;
    clear_exp();
    @(posedge clock); @(posedge clock); #3;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    for (int c = 0; c < max_cyc && pending() != 0; c++) begin
      @(posedge clock); #1;
    end
    chk(name, 64'(pending()), 64'd0);
  endtask

  task automatic present(input int i, input int k);
    set_src(i, DW'(8*i + k), 32'hB000_0000 | XW'(i << 8) | XW'(k), RW'(4*i + k), 1'b1);
  endtask

  initial begin
    int sent [N];
    int total [N];
    logic [N-1:0] rdy;
    bit chk_full;

    src_dest_idx = '0; src_data = '0; src_rob_idx = '0;
    reset = 1'b0; flush = 1'b0; src_valid = '0;
    #12;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("reset_src_ready", 64'(src_ready), 64'hF);
    chk("reset_cdb_data", 64'(cdb_data), 64'd0);
    do_reset();

    // Single request on source 2
    set_src(2, DW'(7), 32'hDEAD_BEEF, RW'(3), 1'b1);
    exp_order.push_back(2);
    @(posedge clock); #1;
    src_valid = '0;
    @(negedge clock);
`ifdef CDB_BYPASS_EN
    chk("lat_after_e0", 64'(cdb_valid), 64'd1);
`else
    chk("lat_after_e0", 64'(cdb_valid), 64'd0);
`endif
    @(posedge clock); @(negedge clock);
`ifdef CDB_BYPASS_EN
    chk("lat_after_e1", 64'(cdb_valid), 64'd0);
`else
    chk("lat_after_e1", 64'(cdb_valid), 64'd1);
`endif
    @(posedge clock); @(negedge clock);
    chk("lat_after_e2", 64'(cdb_valid), 64'd0);
    @(posedge clock); #1;
    wait_drain("single_drain", 10);

    // All four sources on the same edge
    do_reset();
    for (int i = 0; i < N; i++) exp_order.push_back(i);
    drive_cycle(4'hF, 8'h10);
    wait_drain("all4_drain", 20);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("all4_idle", 64'(cdb_valid), 64'd0);
    @(posedge clock); #1;

    // Backpressure: source 1 sends 3, sources 0 and 2 stay busy
    do_reset();
    total = '{6, 3, 6, 0};
    sent  = '{0, 0, 0, 0};
    chk_full = 1'b0;
    for (int i = 0; i < N; i++) if (total[i] > 0) present(i, 0);
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (chk_full) begin
        chk("src1_ready_full", 64'(src_ready[1]), 64'd0);
        chk_full = 1'b0;
      end
      rdy = src_ready;
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (src_valid[i] && rdy[i]) begin
          sent[i]++;
          if (i == 1 && sent[1] == 2) chk_full = 1'b1;
          if (sent[i] < total[i]) present(i, sent[i]);
          else src_valid[i] = 1'b0;
        end
      end
      if (sent[0] == 6 && sent[1] == 3 && sent[2] == 6 && !chk_full) break;
    end
    chk("bp_all_accepted", 64'(sent[0] + sent[1] + sent[2]), 64'd15);
    wait_drain("bp_drain", 40);

    // Flush with FIFOs loaded and a broadcast on the bus
    do_reset();
    exp_order.push_back(0);
    exp_order.push_back(1);
    drive_cycle(4'hF, 8'h40);
    drive_cycle(4'hF, 8'h50);
    drive_cycle(4'h1, 8'h60);
    chk("pre_flush_valid", 64'(cdb_valid), 64'd1);
    flush = 1'b1;
    set_src(1, DW'(5), 32'h5555_5555, RW'(5), 1'b0);
    @(posedge clock); #1;
    flush = 1'b0; src_valid = '0;
    clear_exp();
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_src_ready", 64'(src_ready), 64'hF);
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("flush_no_stale", 64'(cdb_valid), 64'd0);
    @(posedge clock); #1;
    // last_grant kept at 1 across the flush
    exp_order.push_back(2); exp_order.push_back(3);
    exp_order.push_back(0); exp_order.push_back(1);
    drive_cycle(4'hF, 8'h70);
    wait_drain("post_flush_drain", 20);

    // Asynchronous reset between edges
    do_reset();
    drive_cycle(4'hF, 8'h80);
    drive_cycle(4'hF, 8'h90);
    #2;
    reset = 1'b0;
    #1;
    clear_exp();
    chk("arst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("arst_outputs", 64'({cdb_dest_idx, cdb_data, cdb_rob_idx, cdb_src}), 64'd0);
    chk("arst_src_ready", 64'(src_ready), 64'hF);
    @(negedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < N; i++) exp_order.push_back(i);
    drive_cycle(4'hF, 8'hA0);
    wait_drain("arst_regrant_drain", 20);

    // Data width: all-ones payload, then all-zeros
    drive_one(3, {DW{1'b1}}, 32'hFFFF_FFFF, {RW{1'b1}});
    wait_drain("maxwidth_drain", 10);
    drive_one(3, '0, 32'h0, '0);
    wait_drain("zero_drain", 10);

    repeat (3) @(posedge clock);
    chk("final_pending", 64'(pending()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
